// File: rtl/sram_blit_engine_if.sv
// Control handshake plus source/destination SRAM buses of the rectangle blit engine.
// master = the engine, slave = the controller/RAM side that drives it.
interface sram_blit_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] src_base;
    logic [ADDR_WIDTH-1:0] dst_base;
    logic [8:0]            blit_w;
    logic [7:0]            blit_h;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  dst_en;
    logic                  dst_we;
    logic [ADDR_WIDTH-1:0] dst_addr;
    logic [DATA_WIDTH-1:0] dst_data;

    modport master (
        input  start, src_base, dst_base, blit_w, blit_h, src_data,
        output busy, done, src_addr, dst_en, dst_we, dst_addr, dst_data
    );

    modport slave (
        output start, src_base, dst_base, blit_w, blit_h, src_data,
        input  busy, done, src_addr, dst_en, dst_we, dst_addr, dst_data
    );
endinterface

// File: rtl/sram_blit_engine.sv
// WxH rectangle copy between two 1-cycle-latency SRAMs, one pixel per clock.
// Define SRAM_BLIT_KEY_EN to skip writes of KEY_COLOR pixels (colour-keyed sprites).
module sram_blit_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int SRC_STRIDE = 320,
`ifdef SRAM_BLIT_KEY_EN
    parameter int DST_STRIDE = 320,
    parameter logic [DATA_WIDTH-1:0] KEY_COLOR = '0
`else
    parameter int DST_STRIDE = 320
`endif
) (
    input  logic                clk,
    input  logic                reset,
    sram_blit_engine_if.master  bus
);
    localparam logic [ADDR_WIDTH-1:0] SRC_STEP = ADDR_WIDTH'(SRC_STRIDE);
    localparam logic [ADDR_WIDTH-1:0] DST_STEP = ADDR_WIDTH'(DST_STRIDE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_src_addr;
    logic [ADDR_WIDTH-1:0] r_src_row;
    logic [ADDR_WIDTH-1:0] r_dst_cur;
    logic [ADDR_WIDTH-1:0] r_dst_row;
    logic [ADDR_WIDTH-1:0] r_dst_addr;
    logic [8:0]            r_w;
    logic [8:0]            r_x;
    logic [7:0]            r_h;
    logic [7:0]            r_y;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_we_pipe;

    logic                  w_zero;
    logic                  w_last_x;
    logic                  w_last;
    logic                  w_key_pass;

    assign w_zero   = (bus.blit_w == 9'd0) || (bus.blit_h == 8'd0);
    assign w_last_x = (r_x == r_w - 9'd1);
    assign w_last   = w_last_x && (r_y == r_h - 8'd1);

    // r_dst_cur tracks the destination of the pixel currently being read;
    // it is delayed one cycle into r_dst_addr to line up with the RAM data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_src_addr <= '0;
            r_src_row  <= '0;
            r_dst_cur  <= '0;
            r_dst_row  <= '0;
            r_dst_addr <= '0;
            r_w        <= '0;
            r_x        <= '0;
            r_h        <= '0;
            r_y        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_we_pipe  <= 1'b0;
        end else begin
            r_we_pipe <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_w        <= bus.blit_w;
                        r_h        <= bus.blit_h;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_src_addr <= bus.src_base;
                        r_src_row  <= bus.src_base;
                        r_dst_cur  <= bus.dst_base;
                        r_dst_row  <= bus.dst_base;
                        r_busy     <= 1'b1;
                        r_state    <= w_zero ? S_FIN : S_RUN;
                    end
                end
                S_RUN: begin
                    r_we_pipe  <= 1'b1;
                    r_dst_addr <= r_dst_cur;
                    if (w_last) begin
                        r_state <= S_DRAIN;
                    end else if (w_last_x) begin
                        r_x        <= '0;
                        r_y        <= r_y + 8'd1;
                        r_src_row  <= r_src_row + SRC_STEP;
                        r_src_addr <= r_src_row + SRC_STEP;
                        r_dst_row  <= r_dst_row + DST_STEP;
                        r_dst_cur  <= r_dst_row + DST_STEP;
                    end else begin
                        r_x        <= r_x + 9'd1;
                        r_src_addr <= r_src_addr + 1'b1;
                        r_dst_cur  <= r_dst_cur + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_FIN;
                end
                S_FIN: begin
                    // Zero-size jobs arrive here still busy and pulse done on the way out.
                    r_done  <= r_busy;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SRAM_BLIT_KEY_EN
    assign w_key_pass = (bus.src_data != KEY_COLOR);
`else
    assign w_key_pass = 1'b1;
`endif

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.src_addr = r_src_addr;
    assign bus.dst_addr = r_dst_addr;
    assign bus.dst_we   = r_we_pipe & w_key_pass;
    assign bus.dst_en   = r_we_pipe & w_key_pass;
    assign bus.dst_data = bus.src_data;

endmodule

// File: tb/tb_sram_blit_engine.sv
// Directed bench for sram_blit_engine: models both SRAMs and checks timing, addresses, data.
module tb_sram_blit_engine;
    logic clk;
    logic reset;

    sram_blit_engine_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) bus ();

    sram_blit_engine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] src_mem [0:65535];

    always @(posedge clk) bus.src_data <= src_mem[bus.src_addr];

    int n_vec;
    int n_err;
    int busy_cnt, done_cnt, done_at, en_bad;
    logic [15:0] wa[$];
    logic [7:0]  wd[$];
    int          wj[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_blit(input logic [15:0] sb, input logic [15:0] db,
                            input logic [8:0] w, input logic [7:0] h,
                            input int win, input bit spam);
        int n;
        n = int'(w) * int'(h);
        wa.delete(); wd.delete(); wj.delete();
        busy_cnt = 0; done_cnt = 0; done_at = -1; en_bad = 0;
        @(negedge clk);
        bus.src_base = sb; bus.dst_base = db; bus.blit_w = w; bus.blit_h = h;
        bus.start = 1'b1;
        @(posedge clk);
        for (int j = 1; j <= win; j++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
            if (bus.dst_we !== bus.dst_en) en_bad++;
            if (bus.dst_we === 1'b1) begin
                wa.push_back(bus.dst_addr);
                wd.push_back(bus.dst_data);
                wj.push_back(j);
            end
            bus.start = spam && (j <= n + 2);
            if (spam) begin
                bus.src_base = 16'h7777; bus.dst_base = 16'h5555;
                bus.blit_w = 9'd9; bus.blit_h = 8'd9;
            end
        end
        bus.start = 1'b0;
    endtask

    int e1a [8] = '{1000, 1001, 1002, 1003, 1320, 1321, 1322, 1323};
    int e3a [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    int e3d [4] = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};

    initial begin
        n_vec = 0; n_err = 0;
        for (int a = 0; a < 65536; a++) src_mem[a] = 8'(a) ^ 8'hA5;
        for (int x = 0; x < 4; x++) begin
            src_mem[x]       = 8'(x);
            src_mem[320 + x] = 8'(4 + x);
        end
        src_mem[16'h0500] = 8'd5; src_mem[16'h0501] = 8'd0;
        src_mem[16'h0502] = 8'd7; src_mem[16'h0503] = 8'd0;

        bus.start = 1'b0; bus.src_base = '0; bus.dst_base = '0;
        bus.blit_w = '0; bus.blit_h = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",   bus.busy,     0);
        chk("rst_done",   bus.done,     0);
        chk("rst_srcadr", bus.src_addr, 0);
        chk("rst_dstadr", bus.dst_addr, 0);
        chk("rst_we",     bus.dst_we,   0);
        chk("rst_en",     bus.dst_en,   0);
        reset = 1'b0;

        // 1: 4x2 ramp copy
        run_blit(16'd0, 16'd1000, 9'd4, 8'd2, 14, 1'b0);
        chk("t1_busy",   busy_cnt, 9);
        chk("t1_doneat", done_at, 10);
        chk("t1_ndone",  done_cnt, 1);
        chk("t1_nwr",    wa.size(), 8);
        chk("t1_en",     en_bad, 0);
        if (wa.size() == 8) begin
            chk("t1_first_j", wj[0], 2);
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("t1_addr%0d", i), wa[i], e1a[i]);
                chk($sformatf("t1_data%0d", i), wd[i], i);
            end
        end

        // 2: zero-size rectangles
        run_blit(16'd0, 16'd1000, 9'd0, 8'd5, 6, 1'b0);
        chk("t2a_nwr",    wa.size(), 0);
        chk("t2a_doneat", done_at, 2);
        chk("t2a_busy",   busy_cnt, 1);
        run_blit(16'd0, 16'd1000, 9'd3, 8'd0, 6, 1'b0);
        chk("t2b_nwr",    wa.size(), 0);
        chk("t2b_doneat", done_at, 2);
        chk("t2b_ndone",  done_cnt, 1);

        // 3: destination address wrap
        run_blit(16'h0010, 16'hFFFE, 9'd4, 8'd1, 9, 1'b0);
        chk("t3_nwr",    wa.size(), 4);
        chk("t3_doneat", done_at, 6);
        if (wa.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t3_addr%0d", i), wa[i], e3a[i]);
                chk($sformatf("t3_data%0d", i), wd[i], e3d[i]);
            end

        // 4: reset in the third cycle of an 8x8 copy
        @(negedge clk);
        bus.src_base = 16'd0; bus.dst_base = 16'd2000;
        bus.blit_w = 9'd8; bus.blit_h = 8'd8; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk("t4_we_after_rst",   bus.dst_we,   0);
        chk("t4_busy_after_rst", bus.busy,     0);
        chk("t4_src_after_rst",  bus.src_addr, 0);
        reset = 1'b0;
        done_cnt = 0; en_bad = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
            if (bus.dst_we) en_bad++;
        end
        chk("t4_no_done", done_cnt, 0);
        chk("t4_no_we",   en_bad,   0);
        run_blit(16'd0, 16'd2000, 9'd8, 8'd8, 70, 1'b0);
        chk("t4_nwr",    wa.size(), 64);
        chk("t4_doneat", done_at, 66);
        chk("t4_busy",   busy_cnt, 65);
        if (wa.size() == 64) begin
            chk("t4_addr0",  wa[0],  2000);
            chk("t4_data0",  wd[0],  0);
            chk("t4_addr63", wa[63], 4247);
            chk("t4_data63", wd[63], 8'h62);
        end

        // 5: start held high while busy, inputs scrambled after capture
        run_blit(16'd0, 16'd1000, 9'd4, 8'd2, 18, 1'b1);
        chk("t5_ndone",  done_cnt, 1);
        chk("t5_doneat", done_at, 10);
        chk("t5_nwr",    wa.size(), 8);
        chk("t5_busy",   busy_cnt, 9);
        if (wa.size() == 8) chk("t5_addr7", wa[7], 1323);

        // 6: colour-keyed row {5,0,7,0}
        run_blit(16'h0500, 16'd3000, 9'd4, 8'd1, 9, 1'b0);
        chk("t6_doneat", done_at, 6);
`ifdef SRAM_BLIT_KEY_EN
        chk("t6_nwr", wa.size(), 2);
        if (wa.size() == 2) begin
            chk("t6_addr0", wa[0], 3000);
            chk("t6_data0", wd[0], 5);
            chk("t6_addr1", wa[1], 3002);
            chk("t6_data1", wd[1], 7);
        end
`else
        chk("t6_nwr", wa.size(), 4);
        if (wa.size() == 4) begin
            chk("t6_addr1", wa[1], 3001);
            chk("t6_data1", wd[1], 0);
            chk("t6_data2", wd[2], 7);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
